// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants and helpers for the LFSR PRBS generator
//
// Contents:
//   MODE_FIB / MODE_GAL  values of the mode input
//   default_fib_taps()   maximal-length Fibonacci tap masks, widths 3..16
//   default_gal_poly()   maximal-length Galois feedback masks, widths 3..16
//   lfsr_params_ok()     elaboration-time legality check of the parameter set
package lfsr_pkg;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  localparam int LFSR_MIN_WIDTH = 3;
  localparam int LFSR_MAX_WIDTH = 32;

  // Bit i set means state[i] feeds the XOR; the register shifts towards the MSB
  // and the feedback enters bit 0.
  function automatic logic [31:0] default_fib_taps(input int width);
    logic [31:0] taps;
    case (width)
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

  // Lower coefficients of a primitive polynomial; the x^width term is implied.
  function automatic logic [31:0] default_gal_poly(input int width);
    logic [31:0] poly;
    case (width)
      3:       poly = 32'h0000_0003;
      4:       poly = 32'h0000_0003;
      5:       poly = 32'h0000_0005;
      6:       poly = 32'h0000_0003;
      7:       poly = 32'h0000_0003;
      8:       poly = 32'h0000_001D;
      9:       poly = 32'h0000_0011;
      10:      poly = 32'h0000_0009;
      11:      poly = 32'h0000_0005;
      12:      poly = 32'h0000_0053;
      13:      poly = 32'h0000_001B;
      14:      poly = 32'h0000_0443;
      15:      poly = 32'h0000_0003;
      16:      poly = 32'h0000_100B;
      default: poly = 32'h0000_0000;
    endcase
    return poly;
  endfunction

  // A zero seed would lock the register at zero, and an empty tap set never
  // produces a sequence, so both are rejected along with out-of-range widths.
  function automatic bit lfsr_params_ok(input int          width,
                                        input logic [31:0] seed,
                                        input logic [31:0] fib_taps,
                                        input logic [31:0] gal_poly);
    return (width >= LFSR_MIN_WIDTH) && (width <= LFSR_MAX_WIDTH) &&
           (seed != 32'd0) && (fib_taps != 32'd0) && (gal_poly != 32'd0);
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational next-state function of the LFSR
//
// Ports:
//   state       in   WIDTH  current register contents
//   mode        in   1      MODE_FIB or MODE_GAL
//   fib_taps    in   WIDTH  Fibonacci tap mask
//   gal_poly    in   WIDTH  Galois feedback mask
//   next_state  out  WIDTH  register contents after one step
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] state,
  input  logic             mode,
  input  logic [WIDTH-1:0] fib_taps,
  input  logic [WIDTH-1:0] gal_poly,
  output logic [WIDTH-1:0] next_state
);

  logic             fib_bit;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;

  always_comb begin
    fib_bit    = ^(state & fib_taps);
    fib_next   = {state[WIDTH-2:0], fib_bit};
    // The bit shifted out of the MSB is the x^WIDTH term; reduce it modulo
    // the polynomial by folding in the lower coefficients.
    gal_next   = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? gal_poly : '0);
    next_state = (mode == MODE_GAL) ? gal_next : fib_next;
  end

endmodule

// File: rtl/lfsr_prbs_gen.sv
// rtl/lfsr_prbs_gen.sv - LFSR PRBS generator with seed load, lock-up recovery and period counter
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-low reset
//   en       in   1      advance one step this cycle
//   mode     in   1      0 = Fibonacci, 1 = Galois
//   load     in   1      load seed_in this cycle (wins over en)
//   seed_in  in   WIDTH  seed value for load; zero is replaced by SEED
//   state    out  WIDTH  current register contents
//   bit_out  out  1      serial PRBS bit, state[WIDTH-1]
//   count    out  WIDTH  steps since last load, reset or wrap (saturating)
//   wrap     out  1      one-cycle pulse when a step returns to the active seed
//   lockup   out  1      one-cycle pulse when a zero seed/state was replaced by SEED
module lfsr_prbs_gen
  import lfsr_pkg::*;
#(
  parameter int             WIDTH    = 8,
  parameter logic [WIDTH-1:0] FIB_TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] GAL_POLY = 8'h1D,
  parameter logic [WIDTH-1:0] SEED     = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  if (!lfsr_params_ok(WIDTH, 32'(SEED), 32'(FIB_TAPS), 32'(GAL_POLY))) begin : g_param_error
    $error("lfsr_prbs_gen: illegal WIDTH, zero SEED or empty tap mask");
  end

  logic [WIDTH-1:0] seed_r;
  logic [WIDTH-1:0] next_state;

  lfsr_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .state     (state),
    .mode      (mode),
    .fib_taps  (FIB_TAPS),
    .gal_poly  (GAL_POLY),
    .next_state(next_state)
  );

  assign bit_out = state[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= SEED;
      seed_r <= SEED;
      count  <= '0;
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end else begin
      // Pulses default low so each is exactly one cycle wide.
      wrap   <= 1'b0;
      lockup <= 1'b0;
      if (load) begin
        count <= '0;
        if (seed_in == '0) begin
          state  <= SEED;
          seed_r <= SEED;
          lockup <= 1'b1;
        end else begin
          state  <= seed_in;
          seed_r <= seed_in;
        end
      end else if (state == '0) begin
        // All-zero is a fixed point of both feedback forms; escape it even
        // when not stepping so a corrupted register cannot stay stuck.
        state  <= SEED;
        seed_r <= SEED;
        count  <= '0;
        lockup <= 1'b1;
      end else if (en) begin
        state <= next_state;
        if (next_state == seed_r) begin
          count <= '0;
          wrap  <= 1'b1;
        end else if (count != COUNT_MAX) begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/lfsr_prbs_gen.md
# lfsr_prbs_gen

Parametrised LFSR pseudo-random sequence generator for the sequential_circuits library, and the next generation of the fixed 3-bit shift register. Adds configurable width, run-time Fibonacci/Galois mode, gated stepping, and seed loading with zero-seed lock-up protection. Also provides a period counter with a wrap pulse, so benches and BIST logic can confirm the sequence length.

## Interface
- WIDTH, 8: register width, legal 3..32.
- FIB_TAPS, 8'hB8: Fibonacci tap mask; bit i set means state[i] feeds the XOR.
- GAL_POLY, 8'h1D: Galois feedback mask; x^WIDTH term implied, bit i is coefficient of x^i.
- SEED, 8'h01: reset and recovery seed; must be non-zero.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- en  in  1  advance one step this cycle.
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled each step.
- load  in  1  load seed_in this cycle.
- seed_in  in  WIDTH  seed value for load.
- state  out  WIDTH  current register contents.
- bit_out  out  1  serial PRBS bit, equal to state[WIDTH-1].
- count  out  WIDTH  steps since the last load, reset or wrap.
- wrap  out  1  one-cycle pulse when a step returns state to the active seed.
- lockup  out  1  one-cycle pulse when a zero seed or zero state was replaced by SEED.

## Operation
- Internal registers are state, seed_r (the active seed), count, wrap and lockup.
- **Priority per rising edge:** reset (rst=0), then load, then en, then hold.
- **Reset:** state=SEED, seed_r=SEED, count=0, wrap=0, lockup=0.
- **Load with non-zero seed_in:** state=seed_in, seed_r=seed_in, count=0. en is ignored that cycle.
- **Load with seed_in==0:** state=SEED, seed_r=SEED, count=0, lockup=1 for one cycle.
- **Fibonacci step:** fb = ^(state & FIB_TAPS); next = {state[WIDTH-2:0], fb}.
- **Galois step:** next = {state[WIDTH-2:0],1'b0} ^ (state[WIDTH-1] ? GAL_POLY : 0).
- **Step with next==seed_r:** state=next, count=0, wrap=1 for one cycle.
- **Step with next!=seed_r:** state=next, count=count+1. count saturates at all-ones and never wraps through zero.
- **Defensive recovery:** if state==0 in any non-reset, non-load cycle, regardless of en, load state=SEED, seed_r=SEED, count=0 and pulse lockup.
- **Hold (en=0, load=0):** state, seed_r and count are unchanged; wrap=0 and lockup=0.
- **Mode change mid-run:** takes effect on the next step. count and seed_r are not cleared. wrap compares against seed_r only.
- There are no FSM states beyond the register set above.

## Timing
- All outputs are registered except bit_out, which is a direct tap of the registered state.
- Latency: the effect of en, load or rst is visible on state, count, wrap and lockup one cycle after the sampling edge.
- wrap and lockup are exactly one cycle wide. They cannot both be high in the same cycle; lockup takes precedence.
- With en held high and maximal-length taps, wrap fires every 2^WIDTH-1 steps, and count reaches 2^WIDTH-2 just before each wrap.
- Reset asserted mid-sequence restores the reset values at the next edge. Any pending wrap or lockup pulse is dropped.

## Structure
- Shared package lfsr_pkg holds:
  - the MODE_FIB/MODE_GAL constants;
  - default tap/poly constants for widths 3..16 (maximal-length);
  - a parameter-legality check: WIDTH range, SEED!=0, taps!=0.
- One combinational sub-module, lfsr_next (inputs: state, mode, FIB_TAPS, GAL_POLY; output: next state). The top level holds the registers, seed/lock-up logic and counter.

## Test plan
- **Fibonacci walk:** reset, mode=0, en=1 with defaults -> state sequence 01, 02, 04, 08, 11, 23; bit_out follows state[7].
- **Galois walk:** load seed_in=8'h80, mode=1, en=1 -> state sequence 80, 1D, 3A, 74, E8, CD.
- **Full period:** reset, en=1 for 255 steps in each mode -> wrap pulses exactly once, on step 255; count reads 254 the cycle before and 0 with the pulse; all 255 non-zero states appear exactly once.
- **Zero-seed load:** load=1, seed_in=0 -> next cycle state=01, count=0, lockup=1 for one cycle; wrap stays 0.
- **Priority and hold:** load=1 and en=1 with seed_in=8'h5A -> state=5A and no step taken. Then en=0 for 10 cycles -> state and count are frozen, and wrap and lockup stay 0.
- **Reset mid-run:** after 100 steps, drive rst=0 for one edge -> state=01, count=0, wrap=0, lockup=0. A run of 255 steps after release gives exactly one wrap.
